idex_stage: RTL and testbench

//   Decode->Execute pipeline register for the 5-stage ARM pipeline. Sits directly downstream of the

---
 rtl/pipe_pkg.sv | 15 +
 rtl/hazard_lduse.sv | 34 +++
 rtl/idex_stage.sv | 153 +++++++++++++++
 tb/tb_idex_stage.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control word layout
// and common widths for the 5-stage ARM pipeline.
package pipe_pkg;
  localparam int CTRL_W     = 16;
  localparam int C_REGWRITE = 0;
  localparam int C_MEMTOREG = 1;
  localparam int C_MEMWRITE = 2;
  localparam int C_BRANCH   = 3;
  localparam int C_ALUSRC   = 4;
  localparam int C_ALUCTL   = 5;
  localparam int C_FLAGW    = 8;
  localparam int C_COND     = 10;
  localparam int C_WB_BASE  = 14;
  localparam int PC_REG     = 15;
endpackage

// File: rtl/hazard_lduse.sv
// Load-use hazard detection between D and E.
// Pure combinational; ra3 (store data) is excluded.
module hazard_lduse
  import pipe_pkg::*;
#(
  parameter int RA_W = 4
) (
  input  logic            valid_e,
  input  logic            memtoreg_e,
  input  logic            regwrite_e,
  input  logic [RA_W-1:0] wa3_e,
  input  logic            valid_d,
  input  logic [RA_W-1:0] ra1_d,
  input  logic [RA_W-1:0] ra2_d,
  input  logic            stall_e,
  output logic            lduse_d,
  output logic            stall_d
);

  localparam logic [RA_W-1:0] PC_A = RA_W'(PC_REG);

  logic hit1;
  logic hit2;
  logic load_e;

  // PC reads never depend on a load result
  assign hit1 = (ra1_d == wa3_e) && (ra1_d != PC_A);
  assign hit2 = (ra2_d == wa3_e) && (ra2_d != PC_A);

  assign load_e  = valid_e && memtoreg_e && regwrite_e;
  assign lduse_d = load_e && valid_d && (hit1 || hit2);
  assign stall_d = lduse_d || stall_e;

endmodule

// File: rtl/idex_stage.sv
// Decode->Execute pipeline register with stall,
// flush, load-use bubble insertion and bubble count.
module idex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 4,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter int BCNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_d,
  input  logic [DATA_W-1:0] rd1_d,
  input  logic [DATA_W-1:0] rd2_d,
  input  logic [DATA_W-1:0] rd3_d,
  input  logic [RA_W-1:0]   ra1_d,
  input  logic [RA_W-1:0]   ra2_d,
  input  logic [RA_W-1:0]   ra3_d,
  input  logic [RA_W-1:0]   wa3_d,
  input  logic [DATA_W-1:0] imm_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              stall_e,
  input  logic              flush_e,
  output logic [DATA_W-1:0] rd1_e,
  output logic [DATA_W-1:0] rd2_e,
  output logic [DATA_W-1:0] rd3_e,
  output logic [DATA_W-1:0] imm_e,
  output logic [RA_W-1:0]   ra1_e,
  output logic [RA_W-1:0]   ra2_e,
  output logic [RA_W-1:0]   ra3_e,
  output logic [RA_W-1:0]   wa3_e,
  output logic [CTRL_W-1:0] ctrl_e,
  output logic              valid_e,
  output logic              stall_d,
  output logic              lduse_d,
  output logic [BCNT_W-1:0] bubble_cnt
);

  logic [DATA_W-1:0] rd1_q, rd1_nx;
  logic [DATA_W-1:0] rd2_q, rd2_nx;
  logic [DATA_W-1:0] rd3_q, rd3_nx;
  logic [DATA_W-1:0] imm_q, imm_nx;
  logic [RA_W-1:0]   ra1_q, ra1_nx;
  logic [RA_W-1:0]   ra2_q, ra2_nx;
  logic [RA_W-1:0]   ra3_q, ra3_nx;
  logic [RA_W-1:0]   wa3_q, wa3_nx;
  logic [CTRL_W-1:0] ctrl_q, ctrl_nx;
  logic              valid_q, valid_nx;
  logic [BCNT_W-1:0] bcnt_q, bcnt_nx;
  logic              bubble;

  hazard_lduse #(
    .RA_W(RA_W)
  ) u_haz (
    .valid_e   (valid_q),
    .memtoreg_e(ctrl_q[C_MEMTOREG]),
    .regwrite_e(ctrl_q[C_REGWRITE]),
    .wa3_e     (wa3_q),
    .valid_d   (valid_d),
    .ra1_d     (ra1_d),
    .ra2_d     (ra2_d),
    .stall_e   (stall_e),
    .lduse_d   (lduse_d),
    .stall_d   (stall_d)
  );

  // flush beats stall; stall beats load-use
  assign bubble = flush_e || (!stall_e && lduse_d);

  always_comb begin
    rd1_nx   = rd1_q;
    rd2_nx   = rd2_q;
    rd3_nx   = rd3_q;
    imm_nx   = imm_q;
    ra1_nx   = ra1_q;
    ra2_nx   = ra2_q;
    ra3_nx   = ra3_q;
    wa3_nx   = wa3_q;
    ctrl_nx  = ctrl_q;
    valid_nx = valid_q;
    if (bubble) begin
      rd1_nx   = '0;
      rd2_nx   = '0;
      rd3_nx   = '0;
      imm_nx   = '0;
      ra1_nx   = '0;
      ra2_nx   = '0;
      ra3_nx   = '0;
      wa3_nx   = '0;
      ctrl_nx  = '0;
      valid_nx = 1'b0;
    end else if (!stall_e) begin
      rd1_nx   = rd1_d;
      rd2_nx   = rd2_d;
      rd3_nx   = rd3_d;
      imm_nx   = imm_d;
      ra1_nx   = ra1_d;
      ra2_nx   = ra2_d;
      ra3_nx   = ra3_d;
      wa3_nx   = wa3_d;
      ctrl_nx  = valid_d ? ctrl_d : '0;
      valid_nx = valid_d;
    end
  end

  always_comb begin
    bcnt_nx = bcnt_q;
    if (bubble && (bcnt_q != {BCNT_W{1'b1}}))
      bcnt_nx = bcnt_q + BCNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd1_q   <= '0;
      rd2_q   <= '0;
      rd3_q   <= '0;
      imm_q   <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      ra3_q   <= '0;
      wa3_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      bcnt_q  <= '0;
    end else begin
      rd1_q   <= rd1_nx;
      rd2_q   <= rd2_nx;
      rd3_q   <= rd3_nx;
      imm_q   <= imm_nx;
      ra1_q   <= ra1_nx;
      ra2_q   <= ra2_nx;
      ra3_q   <= ra3_nx;
      wa3_q   <= wa3_nx;
      ctrl_q  <= ctrl_nx;
      valid_q <= valid_nx;
      bcnt_q  <= bcnt_nx;
    end
  end

  assign rd1_e      = rd1_q;
  assign rd2_e      = rd2_q;
  assign rd3_e      = rd3_q;
  assign imm_e      = imm_q;
  assign ra1_e      = ra1_q;
  assign ra2_e      = ra2_q;
  assign ra3_e      = ra3_q;
  assign wa3_e      = wa3_q;
  assign ctrl_e     = ctrl_q;
  assign valid_e    = valid_q;
  assign bubble_cnt = bcnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Self-checking bench for idex_stage against a
// behavioural model of the E-stage register.
module tb_idex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_d;
  logic [31:0] rd1_d, rd2_d, rd3_d, imm_d;
  logic [3:0]  ra1_d, ra2_d, ra3_d, wa3_d;
  logic [15:0] ctrl_d;
  logic        stall_e, flush_e;

  logic [31:0] rd1_e, rd2_e, rd3_e, imm_e;
  logic [3:0]  ra1_e, ra2_e, ra3_e, wa3_e;
  logic [15:0] ctrl_e;
  logic        valid_e, stall_d, lduse_d;
  logic [15:0] bubble_cnt;

  logic [31:0] s_rd1, s_rd2, s_rd3, s_imm;
  logic [3:0]  s_ra1, s_ra2, s_ra3, s_wa3;
  logic [15:0] s_ctrl;
  logic        s_valid, s_stall_d, s_lduse;
  logic [1:0]  s_cnt;

  int checks = 0;
  int failures = 0;

  // model of E-stage contents
  logic [31:0] m_rd1, m_rd2, m_rd3, m_imm;
  logic [3:0]  m_ra1, m_ra2, m_ra3, m_wa3;
  logic [15:0] m_ctrl;
  logic        m_valid;
  int          m_cnt;
  int          m_cnt2;

  localparam logic [15:0] LDR_CTRL =
    16'((1 << C_MEMTOREG) | (1 << C_REGWRITE));
  localparam logic [15:0] ADD_CTRL =
    16'(1 << C_REGWRITE);

  always #5 clk = ~clk;

  idex_stage dut (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rd3_d(rd3_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .ra3_d(ra3_d),
    .wa3_d(wa3_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .rd3_e(rd3_e),
    .imm_e(imm_e), .ra1_e(ra1_e), .ra2_e(ra2_e),
    .ra3_e(ra3_e), .wa3_e(wa3_e), .ctrl_e(ctrl_e),
    .valid_e(valid_e), .stall_d(stall_d),
    .lduse_d(lduse_d), .bubble_cnt(bubble_cnt)
  );

  idex_stage #(.BCNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .valid_d(valid_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rd3_d(rd3_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .ra3_d(ra3_d),
    .wa3_d(wa3_d), .imm_d(imm_d), .ctrl_d(ctrl_d),
    .stall_e(stall_e), .flush_e(flush_e),
    .rd1_e(s_rd1), .rd2_e(s_rd2), .rd3_e(s_rd3),
    .imm_e(s_imm), .ra1_e(s_ra1), .ra2_e(s_ra2),
    .ra3_e(s_ra3), .wa3_e(s_wa3), .ctrl_e(s_ctrl),
    .valid_e(s_valid), .stall_d(s_stall_d),
    .lduse_d(s_lduse), .bubble_cnt(s_cnt)
  );

  function automatic logic ref_lduse();
    logic dep1, dep2;
    dep1 = (ra1_d == m_wa3) && (ra1_d != 4'd15);
    dep2 = (ra2_d == m_wa3) && (ra2_d != 4'd15);
    return m_valid && m_ctrl[C_MEMTOREG] &&
           m_ctrl[C_REGWRITE] && valid_d &&
           (dep1 || dep2);
  endfunction

  task automatic model_clear();
    m_rd1 = 0; m_rd2 = 0; m_rd3 = 0; m_imm = 0;
    m_ra1 = 0; m_ra2 = 0; m_ra3 = 0; m_wa3 = 0;
    m_ctrl = 0; m_valid = 0;
  endtask

  task automatic model_bubble();
    model_clear();
    if (m_cnt < 65535) m_cnt++;
    if (m_cnt2 < 3) m_cnt2++;
  endtask

  // one clock edge: model advances, then sample
  task automatic step();
    if (flush_e) model_bubble();
    else if (stall_e) begin end
    else if (ref_lduse()) model_bubble();
    else begin
      m_rd1 = rd1_d; m_rd2 = rd2_d; m_rd3 = rd3_d;
      m_imm = imm_d; m_ra1 = ra1_d; m_ra2 = ra2_d;
      m_ra3 = ra3_d; m_wa3 = wa3_d;
      m_valid = valid_d;
      m_ctrl = valid_d ? ctrl_d : 16'h0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_d = 0; rd1_d = 0; rd2_d = 0; rd3_d = 0;
    imm_d = 0; ra1_d = 0; ra2_d = 0; ra3_d = 0;
    wa3_d = 0; ctrl_d = 0; stall_e = 0; flush_e = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    model_clear();
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({valid_e, ctrl_e, bubble_cnt, rd1_e, wa3_e} !== '0) begin
      failures++;
      $display("FAIL reset_init got v=%b c=%h n=%0d",
               valid_e, ctrl_e, bubble_cnt);
    end
    flush_e = 1;
    valid_d = 1;
    for (int i = 0; i < 5; i++) step();
    flush_e = 0;
    rd1_d = 32'hDEAD_BEEF;
    ctrl_d = 16'h00F0;
    step();
    checks++;
    if (valid_e !== 1'b1 || bubble_cnt !== 16'd5) begin
      failures++;
      $display("FAIL reset_pre got v=%b n=%0d want 1 5",
               valid_e, bubble_cnt);
    end
    #2;
    reset = 1;
    #1;
    checks++;
    if ({rd1_e, rd2_e, rd3_e, imm_e, ra1_e, ra2_e,
         ra3_e, wa3_e, ctrl_e, valid_e,
         bubble_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_async got v=%b rd1=%h n=%0d want 0",
               valid_e, rd1_e, bubble_cnt);
    end
    @(posedge clk);
    #1;
    reset = 0;
    idle_inputs();
    model_clear();
    m_cnt = 0;
    m_cnt2 = 0;
  endtask

  task automatic test_capture();
    do_reset();
    valid_d = 1;
    rd1_d = 32'h1234;
    wa3_d = 4'd3;
    ctrl_d = 16'h0021;
    step();
    checks++;
    if (rd1_e !== 32'h1234 || wa3_e !== 4'd3 ||
        ctrl_e !== 16'h0021 || valid_e !== 1'b1) begin
      failures++;
      $display("FAIL capture got rd1=%h wa3=%0d c=%h v=%b",
               rd1_e, wa3_e, ctrl_e, valid_e);
    end
    valid_d = 0;
    ctrl_d = 16'hFFFF;
    step();
    checks++;
    if (valid_e !== 1'b0 || ctrl_e !== 16'h0 ||
        bubble_cnt !== 16'd0) begin
      failures++;
      $display("FAIL capture_inv got v=%b c=%h n=%0d",
               valid_e, ctrl_e, bubble_cnt);
    end
  endtask

  task automatic test_lduse();
    logic [15:0] n0;
    do_reset();
    valid_d = 1;
    wa3_d = 4'd2;
    ra1_d = 4'd7;
    ctrl_d = LDR_CTRL;
    step();
    ra1_d = 4'd2;
    ra2_d = 4'd1;
    wa3_d = 4'd4;
    ctrl_d = ADD_CTRL;
    #1;
    checks++;
    if (lduse_d !== 1'b1 || stall_d !== 1'b1) begin
      failures++;
      $display("FAIL lduse_det got l=%b s=%b want 1 1",
               lduse_d, stall_d);
    end
    n0 = bubble_cnt;
    step();
    checks++;
    if (valid_e !== 1'b0 || ctrl_e !== 16'h0 ||
        bubble_cnt !== n0 + 16'd1) begin
      failures++;
      $display("FAIL lduse_bub got v=%b c=%h n=%0d",
               valid_e, ctrl_e, bubble_cnt);
    end
    step();
    checks++;
    if (valid_e !== 1'b1 || wa3_e !== 4'd4 ||
        ra1_e !== 4'd2 || ctrl_e !== ADD_CTRL) begin
      failures++;
      $display("FAIL lduse_cap got v=%b wa3=%0d ra1=%0d",
               valid_e, wa3_e, ra1_e);
    end
  endtask

  task automatic test_r15();
    do_reset();
    valid_d = 1;
    wa3_d = 4'd15;
    ctrl_d = LDR_CTRL;
    step();
    ra1_d = 4'd15;
    ra2_d = 4'd1;
    wa3_d = 4'd5;
    rd1_d = 32'h0000_1008;
    ctrl_d = ADD_CTRL;
    #1;
    checks++;
    if (lduse_d !== 1'b0 || stall_d !== 1'b0) begin
      failures++;
      $display("FAIL r15_det got l=%b s=%b want 0 0",
               lduse_d, stall_d);
    end
    step();
    checks++;
    if (valid_e !== 1'b1 || ra1_e !== 4'd15 ||
        rd1_e !== 32'h0000_1008) begin
      failures++;
      $display("FAIL r15_cap got v=%b ra1=%0d rd1=%h",
               valid_e, ra1_e, rd1_e);
    end
  endtask

  task automatic test_stall();
    do_reset();
    valid_d = 1;
    rd1_d = 32'hCAFE_0001;
    imm_d = 32'h55;
    wa3_d = 4'd6;
    ctrl_d = LDR_CTRL;
    step();
    stall_e = 1;
    for (int i = 0; i < 3; i++) begin
      rd1_d = $urandom;
      imm_d = $urandom;
      ra1_d = 4'd6;
      wa3_d = 4'($urandom_range(0, 14));
      #1;
      checks++;
      if (stall_d !== 1'b1 || lduse_d !== 1'b1) begin
        failures++;
        $display("FAIL stall_sd got s=%b l=%b want 1 1",
                 stall_d, lduse_d);
      end
      step();
      checks++;
      if (rd1_e !== 32'hCAFE_0001 || imm_e !== 32'h55 ||
          wa3_e !== 4'd6 || valid_e !== 1'b1 ||
          bubble_cnt !== 16'd0) begin
        failures++;
        $display("FAIL stall_hold got rd1=%h imm=%h n=%0d",
                 rd1_e, imm_e, bubble_cnt);
      end
    end
    flush_e = 1;
    step();
    checks++;
    if (valid_e !== 1'b0 || rd1_e !== 32'h0 ||
        ctrl_e !== 16'h0 || bubble_cnt !== 16'd1) begin
      failures++;
      $display("FAIL stall_flush got v=%b rd1=%h n=%0d",
               valid_e, rd1_e, bubble_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    flush_e = 1;
    valid_d = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      checks++;
      if (s_cnt !== 2'((i > 3) ? 3 : i)) begin
        failures++;
        $display("FAIL sat_cnt step %0d got %0d want %0d",
                 i, s_cnt, (i > 3) ? 3 : i);
      end
    end
    checks++;
    if (bubble_cnt !== 16'd5) begin
      failures++;
      $display("FAIL sat_wide got %0d want 5", bubble_cnt);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      valid_d = ($urandom_range(0, 9) != 0);
      rd1_d = $urandom; rd2_d = $urandom;
      rd3_d = $urandom; imm_d = $urandom;
      ra1_d = ($urandom_range(0, 4) == 0) ? 4'd15 :
              4'($urandom_range(0, 3));
      ra2_d = 4'($urandom_range(0, 3));
      ra3_d = 4'($urandom);
      wa3_d = ($urandom_range(0, 5) == 0) ? 4'd15 :
              4'($urandom_range(0, 3));
      ctrl_d = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        ctrl_d = ctrl_d | LDR_CTRL;
      stall_e = ($urandom_range(0, 4) == 0);
      flush_e = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (lduse_d !== ref_lduse() ||
          stall_d !== (ref_lduse() | stall_e)) begin
        failures++;
        $display("FAIL rnd_haz cyc %0d got l=%b s=%b want %b",
                 i, lduse_d, stall_d, ref_lduse());
      end
      step();
      checks++;
      if ({rd1_e, rd2_e, rd3_e, imm_e, ra1_e, ra2_e,
           ra3_e, wa3_e, ctrl_e, valid_e} !==
          {m_rd1, m_rd2, m_rd3, m_imm, m_ra1, m_ra2,
           m_ra3, m_wa3, m_ctrl, m_valid} ||
          bubble_cnt !== 16'(m_cnt)) begin
        failures++;
        $display("FAIL rnd_e cyc %0d got v=%b c=%h n=%0d want v=%b c=%h n=%0d",
                 i, valid_e, ctrl_e, bubble_cnt,
                 m_valid, m_ctrl, m_cnt);
      end
      checks++;
      if ({s_rd1, s_rd2, s_rd3, s_imm, s_ra1, s_ra2,
           s_ra3, s_wa3, s_ctrl, s_valid,
           s_stall_d, s_lduse} !==
          {m_rd1, m_rd2, m_rd3, m_imm, m_ra1, m_ra2,
           m_ra3, m_wa3, m_ctrl, m_valid,
           ref_lduse() | stall_e, ref_lduse()} ||
          s_cnt !== 2'(m_cnt2)) begin
        failures++;
        $display("FAIL rnd_narrow cyc %0d got v=%b n=%0d want v=%b n=%0d",
                 i, s_valid, s_cnt, m_valid, m_cnt2);
      end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    model_clear();
    m_cnt = 0;
    m_cnt2 = 0;
    test_reset();
    test_capture();
    test_lduse();
    test_r15();
    test_stall();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
